// File: rtl/ram_port_a_arb_pkg.sv
// Shared types for the port-A arbiter: controller states and master indices.
package ram_port_a_arb_pkg;

  // Controller states: sweep the RAM with the init word, then serve masters.
  typedef logic [0:0] state_t;
  localparam state_t CLEAR = 1'b0;
  localparam state_t RUN   = 1'b1;

  // Master index, also the encoding of the remembered last grant.
  typedef logic [0:0] mst_t;
  localparam mst_t M0 = 1'b0;
  localparam mst_t M1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to the
// requester that was not granted last. Purely combinational.
module rr_arb2
  import ram_port_a_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  mst_t       last_grant_i,
  output logic [1:0] grant_o
);

  // One-hot grant from the request vector and the previous winner.
  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = (last_grant_i == M1) ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram_port_a_arb.sv
// Port-A sharer for the dual-port RAM: clears every word after reset, then
// round-robins single-cycle commands from m0 (CPU) and m1 (loader/debug).
// Read data comes back one cycle after acceptance straight from the RAM q_a.
module ram_port_a_arb
  import ram_port_a_arb_pkg::*;
#(
  parameter  int                 DEPTH      = 2048,
  parameter  int                 WIDTH      = 8,
  parameter  logic [WIDTH-1:0]   INIT_VALUE = '0,
  localparam int                 DEPTH_BITS = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  init_done,

  input  logic                  m0_cmd_valid,
  output logic                  m0_cmd_ready,
  input  logic                  m0_cmd_write,
  input  logic [DEPTH_BITS-1:0] m0_cmd_address,
  input  logic [WIDTH-1:0]      m0_cmd_data,
  output logic                  m0_rsp_valid,
  output logic [WIDTH-1:0]      m0_rsp_data,

  input  logic                  m1_cmd_valid,
  output logic                  m1_cmd_ready,
  input  logic                  m1_cmd_write,
  input  logic [DEPTH_BITS-1:0] m1_cmd_address,
  input  logic [WIDTH-1:0]      m1_cmd_data,
  output logic                  m1_rsp_valid,
  output logic [WIDTH-1:0]      m1_rsp_data,

  output logic [DEPTH_BITS-1:0] ram_address_a,
  output logic                  ram_wren_a,
  output logic [WIDTH-1:0]      ram_data_a,
  input  logic [WIDTH-1:0]      ram_q_a
);

  localparam logic [DEPTH_BITS-1:0] ADDR_ONE  = DEPTH_BITS'(1);
  localparam logic [DEPTH_BITS-1:0] ADDR_LAST = DEPTH_BITS'(DEPTH - 1);

  state_t                  state_q, state_d;
  logic [DEPTH_BITS-1:0]   clr_addr_q, clr_addr_d;
  mst_t                    last_grant_q, last_grant_d;
  logic                    init_done_q, init_done_d;
  logic [1:0]              rd_pend_q, rd_pend_d;
  logic [DEPTH_BITS-1:0]   addr_hold_q;

  logic                    run;
  logic [1:0]              req;
  logic [1:0]              grant;

  // Masters are only eligible in RUN and never while reset is being applied,
  // so nothing is accepted in the cycle that reset wipes the controller.
  assign run = (state_q == RUN) && !reset;
  assign req = run ? {m1_cmd_valid, m0_cmd_valid} : 2'b00;

  rr_arb2 u_arb (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  // A grant is only issued to a valid requester, so grant doubles as handshake.
  assign m0_cmd_ready = grant[0];
  assign m1_cmd_ready = grant[1];
  assign init_done    = init_done_q;

  // RAM port A drive: the clear sweep, the granted master, or idle with the
  // address held at its last value.
  always_comb begin
    ram_wren_a    = 1'b0;
    ram_address_a = addr_hold_q;
    ram_data_a    = '0;
    if (state_q == CLEAR) begin
      ram_wren_a    = 1'b1;
      ram_address_a = clr_addr_q;
      ram_data_a    = INIT_VALUE;
    end else if (grant[0]) begin
      ram_wren_a    = m0_cmd_write;
      ram_address_a = m0_cmd_address;
      ram_data_a    = m0_cmd_data;
    end else if (grant[1]) begin
      ram_wren_a    = m1_cmd_write;
      ram_address_a = m1_cmd_address;
      ram_data_a    = m1_cmd_data;
    end
  end

  // Next-state: clear counter and exit, last-grant tracking, read-pending flags.
  always_comb begin
    state_d      = state_q;
    clr_addr_d   = clr_addr_q;
    last_grant_d = last_grant_q;
    init_done_d  = init_done_q;
    rd_pend_d    = 2'b00;
    if (state_q == CLEAR) begin
      clr_addr_d = clr_addr_q + ADDR_ONE;
      if (clr_addr_q == ADDR_LAST) begin
        state_d     = RUN;
        init_done_d = 1'b1;
      end
    end else begin
      if (grant[0]) begin
        last_grant_d = M0;
        rd_pend_d[0] = !m0_cmd_write;
      end
      if (grant[1]) begin
        last_grant_d = M1;
        rd_pend_d[1] = !m1_cmd_write;
      end
    end
  end

  // Control state; last_grant resets to M1 so m0 wins the first tie.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= CLEAR;
      clr_addr_q   <= '0;
      last_grant_q <= M1;
      init_done_q  <= 1'b0;
      rd_pend_q    <= 2'b00;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      last_grant_q <= last_grant_d;
      init_done_q  <= init_done_d;
      rd_pend_q    <= rd_pend_d;
    end
  end

  // Remember the driven address so an idle cycle does not toggle the bus.
  always_ff @(posedge clock) begin
    addr_hold_q <= ram_address_a;
  end

  // Responses pass q_a through in the cycle after a read was accepted; a
  // reset in that cycle suppresses the pulse so no stale data escapes.
  assign m0_rsp_valid = rd_pend_q[0] && !reset;
  assign m1_rsp_valid = rd_pend_q[1] && !reset;
  assign m0_rsp_data  = m0_rsp_valid ? ram_q_a : '0;
  assign m1_rsp_data  = m1_rsp_valid ? ram_q_a : '0;

endmodule

// File: tb/tb_ram_port_a_arb.sv
// Bench for ram_port_a_arb: directed vector table, multi-cycle reset corner
// cases, and randomized traffic against a transaction-level model.
module tb_ram_port_a_arb;

  localparam int           DEPTH = 256;
  localparam int           WIDTH = 8;
  localparam int           AW    = $clog2(DEPTH);
  localparam logic [7:0]   IV    = 8'h3C;
  localparam logic         H     = 1'b1;
  localparam logic         L     = 1'b0;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic init_done;
  logic m0_cmd_valid = 1'b0, m0_cmd_ready, m0_cmd_write = 1'b0;
  logic [AW-1:0] m0_cmd_address = '0;
  logic [WIDTH-1:0] m0_cmd_data = '0;
  logic m0_rsp_valid;
  logic [WIDTH-1:0] m0_rsp_data;
  logic m1_cmd_valid = 1'b0, m1_cmd_ready, m1_cmd_write = 1'b0;
  logic [AW-1:0] m1_cmd_address = '0;
  logic [WIDTH-1:0] m1_cmd_data = '0;
  logic m1_rsp_valid;
  logic [WIDTH-1:0] m1_rsp_data;
  logic [AW-1:0] ram_address_a;
  logic ram_wren_a;
  logic [WIDTH-1:0] ram_data_a;
  logic [WIDTH-1:0] ram_q_a;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  ram_port_a_arb #(.DEPTH(DEPTH), .WIDTH(WIDTH), .INIT_VALUE(IV)) dut (
    .clock(clock), .reset(reset), .init_done(init_done),
    .m0_cmd_valid(m0_cmd_valid), .m0_cmd_ready(m0_cmd_ready), .m0_cmd_write(m0_cmd_write),
    .m0_cmd_address(m0_cmd_address), .m0_cmd_data(m0_cmd_data),
    .m0_rsp_valid(m0_rsp_valid), .m0_rsp_data(m0_rsp_data),
    .m1_cmd_valid(m1_cmd_valid), .m1_cmd_ready(m1_cmd_ready), .m1_cmd_write(m1_cmd_write),
    .m1_cmd_address(m1_cmd_address), .m1_cmd_data(m1_cmd_data),
    .m1_rsp_valid(m1_rsp_valid), .m1_rsp_data(m1_rsp_data),
    .ram_address_a(ram_address_a), .ram_wren_a(ram_wren_a),
    .ram_data_a(ram_data_a), .ram_q_a(ram_q_a)
  );

  // Behavioural RAM port A: registered read, read-first on a same-cycle write.
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clock) begin
    if (ram_wren_a) mem[ram_address_a] <= ram_data_a;
    ram_q_a <= mem[ram_address_a];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  int               last_m;
  logic [WIDTH-1:0] shadow [DEPTH];
  logic             pend0, pend1;
  logic [WIDTH-1:0] pdat0, pdat1;
  logic [AW-1:0]    prev_addr;
  logic             e_rdy0, e_rdy1, e_wren, e_rv0, e_rv1;
  logic [AW-1:0]    e_addr;
  logic [WIDTH-1:0] e_wdata, e_rd0, e_rd1;

  task automatic model_reset();
    last_m = 1;
    for (int i = 0; i < DEPTH; i++) shadow[i] = IV;
    pend0 = 1'b0; pend1 = 1'b0; pdat0 = '0; pdat1 = '0;
    prev_addr = AW'(DEPTH - 1);
  endtask

  // Decide this cycle's winner from the arbitration rules and advance memory.
  task automatic model_step();
    int g;
    logic gw;
    logic [AW-1:0] ga;
    logic [WIDTH-1:0] gd;
    g = -1;
    if (m0_cmd_valid && !m1_cmd_valid) g = 0;
    else if (m1_cmd_valid && !m0_cmd_valid) g = 1;
    else if (m0_cmd_valid && m1_cmd_valid) g = (last_m == 1) ? 0 : 1;
    e_rv0 = pend0; e_rd0 = pend0 ? pdat0 : '0;
    e_rv1 = pend1; e_rd1 = pend1 ? pdat1 : '0;
    e_rdy0 = (g == 0); e_rdy1 = (g == 1);
    gw = (g == 0) ? m0_cmd_write   : m1_cmd_write;
    ga = (g == 0) ? m0_cmd_address : m1_cmd_address;
    gd = (g == 0) ? m0_cmd_data    : m1_cmd_data;
    e_wren  = (g >= 0) && gw;
    e_addr  = (g >= 0) ? ga : prev_addr;
    e_wdata = gd;
    pend0 = 1'b0; pend1 = 1'b0;
    if (g >= 0) begin
      last_m = g;
      if (gw) shadow[ga] = gd;
      else if (g == 0) begin pend0 = 1'b1; pdat0 = shadow[ga]; end
      else begin pend1 = 1'b1; pdat1 = shadow[ga]; end
    end
    prev_addr = e_addr;
  endtask

  task automatic check_model();
    check("grant", {m0_cmd_ready, m1_cmd_ready}, {e_rdy0, e_rdy1});
    check("wren", ram_wren_a, e_wren);
    check("addr", ram_address_a, e_addr);
    if (e_wren) check("wdata", ram_data_a, e_wdata);
    check("rsp_valid", {m0_rsp_valid, m1_rsp_valid}, {e_rv0, e_rv1});
    check("rsp_data", {m0_rsp_data, m1_rsp_data}, {e_rd0, e_rd1});
  endtask

  task automatic drive(input logic v0, w0, input logic [AW-1:0] a0, input logic [7:0] d0,
                       input logic v1, w1, input logic [AW-1:0] a1, input logic [7:0] d1);
    m0_cmd_valid = v0; m0_cmd_write = w0; m0_cmd_address = a0; m0_cmd_data = d0;
    m1_cmd_valid = v1; m1_cmd_write = w1; m1_cmd_address = a1; m1_cmd_data = d1;
  endtask

  task automatic drive_random(input int addr_max);
    drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
          AW'($urandom_range(0, addr_max)), 8'($urandom),
          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
          AW'($urandom_range(0, addr_max)), 8'($urandom));
  endtask

  // One model-checked cycle; entered and left at posedge+1.
  task automatic model_cycle();
    model_step();
    @(negedge clock);
    check_model();
    @(posedge clock); #1;
  endtask

  // Clear sweep: n cycles of wren with ascending address, nothing accepted.
  task automatic do_clear(input int n);
    for (int c = 0; c < n; c++) begin
      drive(H, 1'($urandom_range(0, 1)), AW'($urandom), 8'($urandom),
            H, 1'($urandom_range(0, 1)), AW'($urandom), 8'($urandom));
      @(negedge clock);
      check("clear_cycle",
            {ram_wren_a, ram_address_a, ram_data_a, m0_cmd_ready, m1_cmd_ready,
             init_done, m0_rsp_valid, m1_rsp_valid},
            {1'b1, AW'(c), IV, 5'b00000});
      @(posedge clock); #1;
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic v0, w0; logic [AW-1:0] a0; logic [7:0] d0;
    logic v1, w1; logic [AW-1:0] a1; logic [7:0] d1;
    logic rdy0, rdy1, wren, rv0; logic [7:0] rd0; logic rv1; logic [7:0] rd1;
  } vec_t;
  vec_t tbl [$];

  function automatic vec_t mk(input logic v0, w0, input logic [AW-1:0] a0, input logic [7:0] d0,
                              input logic v1, w1, input logic [AW-1:0] a1, input logic [7:0] d1,
                              input logic rdy0, rdy1, wren, rv0, input logic [7:0] rd0,
                              input logic rv1, input logic [7:0] rd1);
    vec_t v;
    v.v0 = v0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.rdy0 = rdy0; v.rdy1 = rdy1; v.wren = wren;
    v.rv0 = rv0; v.rd0 = rd0; v.rv1 = rv1; v.rd1 = rd1;
    return v;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n1;
    //                 v0 w0 a0     d0     v1 w1 a1     d1     rdy0 rdy1 wren rv0 rd0    rv1 rd1
    tbl.push_back(mk(H, L, 8'h05, 8'h00, H, L, 8'h05, 8'h00, H, L, L, L, 8'h00, L, 8'h00));
    tbl.push_back(mk(L, L, 8'h00, 8'h00, H, L, 8'h05, 8'h00, L, H, L, H, IV,    L, 8'h00));
    tbl.push_back(mk(H, H, 8'h10, 8'hA5, L, L, 8'h00, 8'h00, H, L, H, L, 8'h00, H, IV));
    tbl.push_back(mk(H, L, 8'h10, 8'h00, L, L, 8'h00, 8'h00, H, L, L, L, 8'h00, L, 8'h00));
    tbl.push_back(mk(L, L, 8'h00, 8'h00, L, L, 8'h00, 8'h00, L, L, L, H, 8'hA5, L, 8'h00));
    tbl.push_back(mk(H, H, 8'h01, 8'h11, H, H, 8'h02, 8'h22, L, H, H, L, 8'h00, L, 8'h00));
    tbl.push_back(mk(H, H, 8'h01, 8'h11, L, L, 8'h00, 8'h00, H, L, H, L, 8'h00, L, 8'h00));
    tbl.push_back(mk(H, L, 8'h01, 8'h00, H, L, 8'h02, 8'h00, L, H, L, L, 8'h00, L, 8'h00));
    tbl.push_back(mk(H, L, 8'h01, 8'h00, H, L, 8'h02, 8'h00, H, L, L, L, 8'h00, H, 8'h22));
    tbl.push_back(mk(H, L, 8'h01, 8'h00, H, L, 8'h02, 8'h00, L, H, L, H, 8'h11, L, 8'h00));
    tbl.push_back(mk(H, L, 8'h01, 8'h00, H, L, 8'h02, 8'h00, H, L, L, L, 8'h00, H, 8'h22));
    tbl.push_back(mk(L, L, 8'h00, 8'h00, L, L, 8'h00, 8'h00, L, L, L, H, 8'h11, L, 8'h00));
    tbl.push_back(mk(L, L, 8'h00, 8'h00, H, L, 8'h00, 8'h00, L, H, L, L, 8'h00, L, 8'h00));
    tbl.push_back(mk(L, L, 8'h00, 8'h00, H, L, 8'h01, 8'h00, L, H, L, L, 8'h00, H, IV));
    tbl.push_back(mk(L, L, 8'h00, 8'h00, H, L, 8'h02, 8'h00, L, H, L, L, 8'h00, H, 8'h11));
    tbl.push_back(mk(L, L, 8'h00, 8'h00, H, L, 8'h03, 8'h00, L, H, L, L, 8'h00, H, 8'h22));
    tbl.push_back(mk(L, L, 8'h00, 8'h00, L, L, 8'h00, 8'h00, L, L, L, L, 8'h00, H, IV));
    tbl.push_back(mk(H, H, 8'h07, 8'h5A, L, L, 8'h00, 8'h00, H, L, H, L, 8'h00, L, 8'h00));
    tbl.push_back(mk(L, L, 8'h00, 8'h00, H, L, 8'h07, 8'h00, L, H, L, L, 8'h00, L, 8'h00));
    tbl.push_back(mk(L, L, 8'h00, 8'h00, L, L, 8'h00, 8'h00, L, L, L, L, 8'h00, H, 8'h5A));

    // Reset state with both masters pushing.
    drive(H, L, 8'h05, 8'h00, H, L, 8'h05, 8'h00);
    @(posedge clock); #1;
    @(negedge clock);
    check("reset_state", {init_done, m0_cmd_ready, m1_cmd_ready, m0_rsp_valid, m1_rsp_valid}, 5'b00000);
    @(posedge clock); #1;
    reset = 1'b0;

    // Full clear sweep, init_done exactly DEPTH cycles after release.
    do_clear(DEPTH);
    check("init_done_rise", init_done, 1'b1);
    model_reset();

    // Directed vectors.
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v0, tbl[i].w0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
      model_step();
      @(negedge clock);
      check($sformatf("vec%0d", i),
            {m0_cmd_ready, m1_cmd_ready, ram_wren_a, m0_rsp_valid, m0_rsp_data, m1_rsp_valid, m1_rsp_data},
            {tbl[i].rdy0, tbl[i].rdy1, tbl[i].wren, tbl[i].rv0, tbl[i].rd0, tbl[i].rv1, tbl[i].rd1});
      @(posedge clock); #1;
    end

    // Continuous contention: strict alternation, no starvation.
    n0 = 0; n1 = 0;
    for (int i = 0; i < 100; i++) begin
      drive(H, L, 8'h01, 8'h00, H, L, 8'h02, 8'h00);
      model_step();
      @(negedge clock);
      check_model();
      n0 += int'(m0_cmd_ready);
      n1 += int'(m1_cmd_ready);
      @(posedge clock); #1;
    end
    check("m0_share", n0, 50);
    check("m1_share", n1, 50);

    // Randomized traffic over a small address window to provoke reuse.
    for (int i = 0; i < 400; i++) begin
      drive_random(15);
      model_cycle();
    end

    // Reset mid-clear: restart from address 0 and take a full DEPTH cycles.
    reset = 1'b1;
    @(negedge clock);
    check("ready_in_reset", {m0_cmd_ready, m1_cmd_ready}, 2'b00);
    @(posedge clock); #1;
    reset = 1'b0;
    do_clear(100);
    reset = 1'b1;
    @(negedge clock);
    check("ready_in_clear_reset", {m0_cmd_ready, m1_cmd_ready, init_done}, 3'b000);
    @(posedge clock); #1;
    reset = 1'b0;
    do_clear(DEPTH);
    check("init_done_rise2", init_done, 1'b1);
    model_reset();

    // Earlier writes are gone after the clear.
    drive(H, L, 8'h10, 8'h00, L, L, 8'h00, 8'h00);
    model_cycle();
    drive(H, L, 8'h07, 8'h00, L, L, 8'h00, 8'h00);
    model_cycle();
    drive(L, L, 8'h00, 8'h00, L, L, 8'h00, 8'h00);
    model_cycle();

    // Read accepted, then reset lands on the response cycle.
    drive(H, L, 8'h01, 8'h00, L, L, 8'h00, 8'h00);
    @(negedge clock);
    check("read_before_reset", m0_cmd_ready, 1'b1);
    @(posedge clock); #1;
    reset = 1'b1;
    m0_cmd_valid = 1'b0;
    @(negedge clock);
    check("rsp_dropped", {m0_rsp_valid, m1_rsp_valid}, 2'b00);
    @(posedge clock); #1;
    reset = 1'b0;
    check("init_done_cleared", init_done, 1'b0);
    do_clear(DEPTH);
    check("init_done_rise3", init_done, 1'b1);
    model_reset();
    for (int i = 0; i < 40; i++) begin
      drive_random(7);
      model_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_port_a_arb.md
Name: ram_port_a_arb

Overview:
- Shares port A (read/write, 1-cycle registered read) of the dual-port RAM `ram_DxW_rrw_p1p1` between two requesters, m0 and m1, using round-robin arbitration.
- After reset, sequences a full-RAM clear before accepting any command.
- Port B is not touched; it stays a dedicated read port outside this block.
- Sits between the CPU-side master (m0) and the loader/debug master (m1) and the shared RAM.

Parameters:
- DEPTH, 2048, RAM word count; must be a power of two ≥ 2.
- WIDTH, 8, RAM data width.
- INIT_VALUE, 0, WIDTH-bit word written to every address during the clear.
- DEPTH_BITS, $clog2(DEPTH), address width (localparam).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- init_done  out  1  high once the clear completes.
- m0_cmd_valid  in  1  m0 command valid.
- m0_cmd_ready  out  1  m0 command accepted this cycle.
- m0_cmd_write  in  1  1 = write, 0 = read.
- m0_cmd_address  in  DEPTH_BITS  m0 word address.
- m0_cmd_data  in  WIDTH  m0 write data.
- m0_rsp_valid  out  1  m0 read data valid.
- m0_rsp_data  out  WIDTH  m0 read data.
- m1_cmd_valid, m1_cmd_ready, m1_cmd_write, m1_cmd_address, m1_cmd_data, m1_rsp_valid, m1_rsp_data  same as m0, for m1.
- ram_address_a  out  DEPTH_BITS  to RAM address_a.
- ram_wren_a  out  1  to RAM wren_a.
- ram_data_a  out  WIDTH  to RAM data_a.
- ram_q_a  in  WIDTH  from RAM q_a.

Behaviour:
- States: CLEAR, RUN.
- Reset:
  - state = CLEAR, clr_addr = 0, last_grant = m1 (so m0 wins the first tie).
  - init_done = 0; both cmd_ready = 0; both rsp_valid = 0.
  - Reset asserted at any point, including mid-CLEAR or while a read is in flight, restarts CLEAR from address 0 and drops any pending response.
- CLEAR:
  - Each cycle: ram_wren_a = 1, ram_address_a = clr_addr, ram_data_a = INIT_VALUE, then clr_addr++.
  - On the cycle that writes address DEPTH-1, the next state is RUN and init_done registers to 1.
  - CLEAR lasts exactly DEPTH cycles; commands are ignored and cmd_ready stays 0 throughout.
- RUN, grant logic (combinational from the valids and last_grant):
  - Only one valid: that master is granted.
  - Both valid: the master not equal to last_grant is granted.
  - Neither valid: no grant; ram_wren_a = 0 and ram_address_a holds its previous value.
  - mX_cmd_ready = 1 only for the granted master; handshake = valid & ready.
  - The granted master's address, data and write bit drive the RAM port combinationally; ram_wren_a = granted & cmd_write.
  - last_grant updates on every handshake.
- Read response:
  - A read accepted at cycle T produces mX_rsp_valid = 1 for exactly cycle T+1, with mX_rsp_data = ram_q_a (combinational pass-through).
  - There is no response backpressure; the requester must accept it.
- Non-selected rsp_data holds 0.
  - Writes produce no response.
- Throughput: one command per cycle total; back-to-back reads from the same master give consecutive rsp_valid pulses.
- Collision on the same cycle:
  - Port A is read-first; this only matters for writes, which emit no response.
  - A read at T+1 to an address written at T returns the new data.
- Port B collision with a port-A write is the RAM's concern; it is not arbitrated here.
- cmd fields are don't-care when valid = 0.

Decomposition:
- Package ram_port_a_arb_pkg holds:
  - the state typedef (CLEAR, RUN);
  - the master-index typedef (M0 = 0, M1 = 1).
- One natural sub-module: rr_arb2, the 2-way round-robin grant logic (inputs req[1:0] and last_grant; output grant one-hot). It is reusable elsewhere.
- Instantiate `ram_DxW_rrw_p1p1` only in the bench/top, not in this block.

Test Plan:
- Reset, then hold both valids high → cmd_ready stays 0 for exactly DEPTH cycles; ram_wren_a = 1 with addresses 0..DEPTH-1 in sequence; init_done rises on cycle DEPTH; a read of address 5 then returns INIT_VALUE.
- m0 writes 0xA5 to address 0x10, then m0 reads 0x10 → m0_rsp_valid pulses one cycle after acceptance with 0xA5; m1_rsp_valid stays 0.
- Both masters issue continuous reads (m0 → addr 1, m1 → addr 2, preloaded 0x11 / 0x22) → grants alternate m0, m1, m0, ...; each rsp_valid pulses every other cycle with the correct data; no starvation over 100 cycles.
- m1 only, 4 back-to-back reads of addresses 0..3 → m1_cmd_ready held at 1; four consecutive m1_rsp_valid pulses with data in order.
- Assert reset at clear cycle 100, release → the clear restarts at address 0 and init_done rises exactly DEPTH cycles after release.
- m0 issues a read at T; reset is asserted at T+1 → m0_rsp_valid = 0 at T+1 and stays 0; the clear restarts.
